morse_tx_encoder: RTL and testbench

- Transmit-side counterpart to the morse decode path: accepts one ASCII character at a time and emits a unit-timed Morse key waveform.
- A dot is 1 unit, a dash 3 units, the intra-character gap 1 unit, the inter-character gap 3 units, and a word gap 7 units.
- Feeds an LED/buzzer pin or, in loopback, the existing dot/dash/space symbol path.

---
 rtl/morse_pkg.sv | 33 +++
 rtl/morse_lut.sv | 61 ++++++
 rtl/morse_tx_encoder.sv | 145 ++++++++++++++
 tb/tb_morse_tx_encoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse encoder types: symbol codes, gap lengths, FSM states
// and the LUT entry packer used by morse_lut.
package morse_pkg;

  localparam logic [1:0] SYM_DOT    = 2'b00;
  localparam logic [1:0] SYM_DASH   = 2'b01;
  localparam logic [1:0] SYM_CSPACE = 2'b10;
  localparam logic [1:0] SYM_WSPACE = 2'b11;

  localparam int DASH_UNITS = 3;
  localparam int CGAP_UNITS = 3;
  localparam int WGAP_UNITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ESPACE,
    ST_CGAP,
    ST_WGAP
  } state_t;

  // Packs {valid, len, pattern}; bits are given right-aligned and
  // stored left-aligned so pattern[4] is always the first element.
  function automatic logic [8:0] morse_ent(
    input logic [2:0] len,
    input logic [4:0] bits
  );
    logic [4:0] w_al;
    w_al = bits << (3'd5 - len);
    return {1'b1, len, w_al};
  endfunction

endpackage

// File: rtl/morse_lut.sv
// ASCII -> Morse element lookup: A-Z, a-z, 0-9, space (len 0).
// Ports: i_char in; o_valid, o_len (0-5), o_pat (MSB first, 1=dash) out.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid,
  output logic [2:0] o_len,
  output logic [4:0] o_pat
);

  logic [7:0] w_up;

  always_comb begin
    w_up = i_char;
    if (i_char inside {[8'h61:8'h7A]})
      w_up = i_char - 8'h20;
    {o_valid, o_len, o_pat} = '0;
    case (w_up)
      "A": {o_valid, o_len, o_pat} = morse_ent(3'd2, 5'b01);
      "B": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1000);
      "C": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1010);
      "D": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b100);
      "E": {o_valid, o_len, o_pat} = morse_ent(3'd1, 5'b0);
      "F": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0010);
      "G": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b110);
      "H": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0000);
      "I": {o_valid, o_len, o_pat} = morse_ent(3'd2, 5'b00);
      "J": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0111);
      "K": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b101);
      "L": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0100);
      "M": {o_valid, o_len, o_pat} = morse_ent(3'd2, 5'b11);
      "N": {o_valid, o_len, o_pat} = morse_ent(3'd2, 5'b10);
      "O": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b111);
      "P": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0110);
      "Q": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1101);
      "R": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b010);
      "S": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b000);
      "T": {o_valid, o_len, o_pat} = morse_ent(3'd1, 5'b1);
      "U": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b001);
      "V": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b0001);
      "W": {o_valid, o_len, o_pat} = morse_ent(3'd3, 5'b011);
      "X": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1001);
      "Y": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1011);
      "Z": {o_valid, o_len, o_pat} = morse_ent(3'd4, 5'b1100);
      "0": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b11111);
      "1": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b01111);
      "2": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b00111);
      "3": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b00011);
      "4": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b00001);
      "5": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b00000);
      "6": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b10000);
      "7": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b11000);
      "8": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b11100);
      "9": {o_valid, o_len, o_pat} = morse_ent(3'd5, 5'b11110);
      " ": {o_valid, o_len, o_pat} = {1'b1, 3'd0, 5'd0};
      default: {o_valid, o_len, o_pat} = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx_encoder.sv
// Morse transmit encoder: one ASCII char in, unit-timed key waveform out.
// Ports: clk, rst (async, active low), char_in/char_valid/char_ready
// handshake, key_out, busy, err pulse, sym_valid/sym_code symbol strobe.
// Build option SYM_OUT_EN enables the loopback symbol stream;
// otherwise sym_valid/sym_code are tied 0.
module morse_tx_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       err,
  output logic       sym_valid,
  output logic [1:0] sym_code
);

  // Word gap is the longest single-state count.
  localparam int CNT_W = $clog2(WGAP_UNITS * UNIT_CYCLES + 1);

  // Gap states stop one cycle short: their final unit cycle is the
  // IDLE cycle in which the next character can be taken, so
  // back-to-back characters see no dead cycle.
  localparam logic [CNT_W-1:0] L_DOT  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DASH = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_CGAP = CNT_W'(CGAP_UNITS * UNIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] L_WGAP = CNT_W'(WGAP_UNITS * UNIT_CYCLES - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pat;
  logic [2:0]       r_rem;
  logic             r_key;
  logic             r_err;

  logic             w_lut_ok;
  logic [2:0]       w_lut_len;
  logic [4:0]       w_lut_pat;
  logic [CNT_W-1:0] w_lim;
  logic             w_last;
  logic             w_acc;
  logic             w_take;
  logic             w_go_mark;
  logic             w_go_wgap;
  logic             w_go_esp;
  logic             w_go_cgap;
  logic             w_go_idle;

  morse_lut u_lut (
    .i_char  (char_in),
    .o_valid (w_lut_ok),
    .o_len   (w_lut_len),
    .o_pat   (w_lut_pat)
  );

  always_comb begin
    w_lim = '0;
    unique case (r_state)
      ST_MARK:   w_lim = r_pat[4] ? L_DASH : L_DOT;
      ST_ESPACE: w_lim = L_DOT;
      ST_CGAP:   w_lim = L_CGAP;
      ST_WGAP:   w_lim = L_WGAP;
      default:   w_lim = '0;
    endcase
  end

  assign w_last    = (r_cnt == w_lim);
  assign w_acc     = (r_state == ST_IDLE) & char_valid;
  assign w_take    = w_acc & w_lut_ok & (w_lut_len != 3'd0);
  assign w_go_wgap = w_acc & w_lut_ok & (w_lut_len == 3'd0);
  assign w_go_mark = w_take | ((r_state == ST_ESPACE) & w_last);
  assign w_go_esp  = (r_state == ST_MARK) & w_last & (r_rem != 3'd0);
  assign w_go_cgap = (r_state == ST_MARK) & w_last & (r_rem == 3'd0);
  assign w_go_idle = ((r_state == ST_CGAP) | (r_state == ST_WGAP)) & w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_rem   <= '0;
      r_key   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc & ~w_lut_ok;
      r_key <= w_go_mark | ((r_state == ST_MARK) & ~w_last);
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      unique case (1'b1)
        w_go_mark: r_state <= ST_MARK;
        w_go_wgap: r_state <= ST_WGAP;
        w_go_esp:  r_state <= ST_ESPACE;
        w_go_cgap: r_state <= ST_CGAP;
        w_go_idle: r_state <= ST_IDLE;
        default:   ;
      endcase
      if (w_take) begin
        r_pat <= w_lut_pat;
        r_rem <= w_lut_len - 3'd1;
      end else if (w_go_esp) begin
        r_pat <= r_pat << 1;
        r_rem <= r_rem - 3'd1;
      end
    end
  end

  assign char_ready = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign key_out    = r_key;
  assign err        = r_err;

`ifdef SYM_OUT_EN
  logic       r_sym_v;
  logic [1:0] r_sym_c;
  logic       w_dash;

  assign w_dash = w_take ? w_lut_pat[4] : r_pat[4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_v <= 1'b0;
      r_sym_c <= SYM_DOT;
    end else begin
      r_sym_v <= w_go_mark | w_go_cgap | w_go_wgap;
      unique case (1'b1)
        w_go_mark: r_sym_c <= w_dash ? SYM_DASH : SYM_DOT;
        w_go_cgap: r_sym_c <= SYM_CSPACE;
        w_go_wgap: r_sym_c <= SYM_WSPACE;
        default:   ;
      endcase
    end
  end

  assign sym_valid = r_sym_v;
  assign sym_code  = r_sym_c;
`else
  assign sym_valid = 1'b0;
  assign sym_code  = 2'b00;
`endif

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Directed bench for morse_tx_encoder at UNIT_CYCLES=4.
// Cycle n = the cycle after the n-th edge following acceptance.
module tb_morse_tx_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       err;
  logic       sym_valid;
  logic [1:0] sym_code;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sym_q[$];

  morse_tx_encoder #(.UNIT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .err        (err),
    .sym_valid  (sym_valid),
    .sym_code   (sym_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sym_valid === 1'b1)
      sym_q.push_back(sym_code);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    char_in = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  // n cycles of key_out at lvl while busy; char_in scrambled meanwhile
  task automatic run(input string tag, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_key"}, key_out, lvl);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_rdy"}, char_ready, 1'b0);
      char_in = 8'($urandom);
      tick();
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_key"}, key_out, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdy"}, char_ready, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  // exp holds codes packed LSB-first, element k at exp[2k+1:2k]
  task automatic sym_chk(input string tag, input int n,
                         input logic [11:0] exp);
    chk({tag, "_n"}, sym_q.size(), n);
    for (int k = 0; k < n && k < sym_q.size(); k++)
      chk({tag, "_code"}, sym_q[k], exp[2*k +: 2]);
    sym_q.delete();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_rdy", char_ready, 1'b1);
    chk("rst_key", key_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_symv", sym_valid, 1'b0);
    chk("rst_symc", sym_code, 2'b00);
    rst = 1'b1;
    tick();
    tick();

    // 'E': high 1-4, low 5-16, ready at 16
    send("E");
    run("E_mark", 1'b1, 4);
    run("E_gap", 1'b0, 11);
    idle_chk("E_end");
`ifdef SYM_OUT_EN
    sym_chk("E_sym", 2, 12'b10_00);
`else
    sym_chk("E_sym", 0, 12'b0);
`endif

    // 'a' back-to-back: 4 / 4 / 12 / 12 = 32 cycles
    send("a");
    run("a_dot", 1'b1, 4);
    run("a_esp", 1'b0, 4);
    run("a_dash", 1'b1, 12);
    run("a_gap", 1'b0, 11);
    idle_chk("a_end");
`ifdef SYM_OUT_EN
    sym_chk("a_sym", 3, 12'b10_01_00);
`else
    sym_chk("a_sym", 0, 12'b0);
`endif

    // 'T' then space: 12 high, 28 continuous low
    send("T");
    run("T_dash", 1'b1, 12);
    run("T_gap", 1'b0, 11);
    idle_chk("T_end");
    send(" ");
    run("sp_gap", 1'b0, 15);
    idle_chk("sp_end");
`ifdef SYM_OUT_EN
    sym_chk("Tsp_sym", 3, 12'b11_10_01);
`else
    sym_chk("Tsp_sym", 0, 12'b0);
`endif

    // '0': five dashes, 88 cycles total
    send("0");
    for (int e = 0; e < 5; e++) begin
      run("z_dash", 1'b1, 12);
      if (e < 4)
        run("z_esp", 1'b0, 4);
    end
    run("z_gap", 1'b0, 11);
    idle_chk("z_end");
`ifdef SYM_OUT_EN
    sym_chk("z_sym", 6, 12'b10_01_01_01_01_01);
`else
    sym_chk("z_sym", 0, 12'b0);
`endif

    // '#': one-cycle err, no activity, then 'E' normally
    send("#");
    chk("hash_err1", err, 1'b1);
    chk("hash_rdy1", char_ready, 1'b1);
    chk("hash_key1", key_out, 1'b0);
    chk("hash_busy1", busy, 1'b0);
    tick();
    idle_chk("hash_c2");
    send("E");
    chk("hE_err", err, 1'b0);
    run("hE_mark", 1'b1, 4);
    run("hE_gap", 1'b0, 11);
    idle_chk("hE_end");
`ifdef SYM_OUT_EN
    sym_chk("hE_sym", 2, 12'b10_00);
`else
    sym_chk("hE_sym", 0, 12'b0);
`endif

    // reset during cycle 6 of a dash drops key at once
    send("T");
    run("rT_dash", 1'b1, 5);
    chk("rT_c6_key", key_out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_key", key_out, 1'b0);
    chk("ar_rdy", char_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    idle_chk("ar_idle");
`ifdef SYM_OUT_EN
    sym_chk("rT_sym", 1, 12'b01);
`else
    sym_chk("rT_sym", 0, 12'b0);
`endif
    send("e");
    run("rE_mark", 1'b1, 4);
    run("rE_gap", 1'b0, 11);
    idle_chk("rE_end");
`ifdef SYM_OUT_EN
    sym_chk("rE_sym", 2, 12'b10_00);
`else
    sym_chk("rE_sym", 0, 12'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
